// File: rtl/apb_master_fsm_if.sv
// Command/response and APB requester signals bundled for the APB master stage.
// The master modport is the requester's view; the slave modport is the view of whatever drives it.
interface apb_master_fsm_if #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDRWIDTH-1:0] req_addr;
   logic [DATAWIDTH-1:0] req_wdata;

   logic                 rsp_valid;
   logic [DATAWIDTH-1:0] rsp_rdata;
   logic                 rsp_err;

   logic                 PSEL1;
   logic                 PSEL2;
   logic                 PENABLE;
   logic                 PWRITE;
   logic [ADDRWIDTH-1:0] PADDR;
   logic [DATAWIDTH-1:0] PWDATA;
   logic                 PREADY;
   logic [DATAWIDTH-1:0] PRDATA;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_fsm.sv
// APB requester: one read/write per command, one-hot PSEL1/PSEL2 decode, wait-state watchdog.
// Latency accept->rsp_valid is 3 cycles plus one per PREADY-low ACCESS cycle; req_ready only in IDLE or completing ACCESS.
module apb_master_fsm #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32,
   parameter int SEL_BIT   = 12,
   parameter int TIMEOUT   = 16
) (
   input logic              PCLK,
   input logic              PRESET,
   apb_master_fsm_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_e;

   localparam bit         WDOG_EN   = (TIMEOUT != 0);
   localparam logic [7:0] WAIT_LAST = WDOG_EN ? 8'(TIMEOUT - 1) : 8'd0;

   state_e               state_q, state_d;
   logic [7:0]           wait_cnt_q, wait_cnt_d;
   logic                 psel1_q, psel1_d;
   logic                 psel2_q, psel2_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
   logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic accept;
   logic wdog_fire;
   logic load;

   assign bus.req_ready = !PRESET &&
                          ((state_q == S_IDLE) || ((state_q == S_ACCESS) && bus.PREADY));
   assign accept        = bus.req_valid && bus.req_ready;
   // Fires in the TIMEOUT-th ACCESS cycle; a PREADY in that same cycle takes precedence.
   assign wdog_fire     = WDOG_EN && (wait_cnt_q == WAIT_LAST);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      psel1_d     = psel1_q;
      psel2_d     = psel2_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      load        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               load = 1'b1;
            end
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end
         S_ACCESS: begin
            if (bus.PREADY) begin
               rsp_valid_d = 1'b1;
               if (!pwrite_q) begin
                  rsp_rdata_d = bus.PRDATA;
               end
               if (accept) begin
                  load = 1'b1;
               end else begin
                  state_d   = S_IDLE;
                  psel1_d   = 1'b0;
                  psel2_d   = 1'b0;
                  penable_d = 1'b0;
               end
            end else if (wdog_fire) begin
               state_d     = S_IDLE;
               psel1_d     = 1'b0;
               psel2_d     = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Shared by the IDLE accept and the back-to-back accept at the end of ACCESS.
      if (load) begin
         state_d    = S_SETUP;
         wait_cnt_d = 8'd0;
         paddr_d    = bus.req_addr;
         pwrite_d   = bus.req_write;
         pwdata_d   = bus.req_wdata;
         psel1_d    = !bus.req_addr[SEL_BIT];
         psel2_d    = bus.req_addr[SEL_BIT];
         penable_d  = 1'b0;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 8'd0;
         psel1_q     <= 1'b0;
         psel2_q     <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         psel1_q     <= psel1_d;
         psel2_q     <= psel2_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.PSEL1     = psel1_q;
   assign bus.PSEL2     = psel2_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   a_psel_onehot: assert property (@(posedge PCLK) disable iff (PRESET)
      !(psel1_q && psel2_q));
   a_penable_sel: assert property (@(posedge PCLK) disable iff (PRESET)
      penable_q |-> (psel1_q || psel2_q));

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm with queued expectations checked by a negedge monitor.
module tb_apb_master_fsm;
   localparam int DW = 32;
   localparam int AW = 32;

   logic PCLK = 1'b0;
   logic PRESET = 1'b1;

   apb_master_fsm_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

   apb_master_fsm #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .SEL_BIT(12), .TIMEOUT(4)) dut (
      .PCLK  (PCLK),
      .PRESET(PRESET),
      .bus   (bus)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int          cyc;
      logic        s1;
      logic        s2;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } setup_t;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   setup_t setup_q[$];
   rsp_t   rsp_q[$];
   setup_t cur;
   setup_t mon_s;
   rsp_t   mon_r;

   // Slave model: wait_n PREADY-low ACCESS cycles, then ready; wait_n < 0 never answers.
   int          wait_n = 0;
   logic [31:0] slave_rdata = 32'h0;
   int          acc_k = 0;

   always @(negedge PCLK) begin
      if ((bus.PSEL1 || bus.PSEL2) && bus.PENABLE) begin
         bus.PREADY = (wait_n >= 0) && (acc_k >= wait_n);
         bus.PRDATA = bus.PREADY ? slave_rdata : 32'hBAD0_BAD0;
         acc_k++;
      end else begin
         acc_k      = 0;
         bus.PREADY = 1'b0;
         bus.PRDATA = 32'hBAD0_BAD0;
      end
   end

   always @(negedge PCLK) begin
      if ((bus.PSEL1 || bus.PSEL2) && !bus.PENABLE) begin
         if (setup_q.size() == 0) begin
            chk("setup_unexpected", 32'(1), 32'(0));
         end else begin
            mon_s = setup_q.pop_front();
            cur   = mon_s;
            chk("setup_cycle", 32'(cyc), 32'(mon_s.cyc));
            chk("setup_psel1", 32'(bus.PSEL1), 32'(mon_s.s1));
            chk("setup_psel2", 32'(bus.PSEL2), 32'(mon_s.s2));
            chk("setup_paddr", bus.PADDR, mon_s.a);
            chk("setup_pwrite", 32'(bus.PWRITE), 32'(mon_s.w));
            if (mon_s.w) chk("setup_pwdata", bus.PWDATA, mon_s.d);
         end
      end else if ((bus.PSEL1 || bus.PSEL2) && bus.PENABLE) begin
         chk("access_psel", 32'({bus.PSEL1, bus.PSEL2}), 32'({cur.s1, cur.s2}));
         chk("access_paddr", bus.PADDR, cur.a);
         chk("access_pwrite", 32'(bus.PWRITE), 32'(cur.w));
      end
      if (bus.rsp_valid === 1'b1) begin
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(1), 32'(0));
         end else begin
            mon_r = rsp_q.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
            chk("rsp_err", 32'(bus.rsp_err), 32'(mon_r.err));
            chk("rsp_rdata", bus.rsp_rdata, mon_r.rdata);
            if (mon_r.err) chk("abort_bus_idle", 32'({bus.PSEL1, bus.PSEL2, bus.PENABLE}), 32'(0));
         end
      end
   end

   // Called at a negedge; returns at the negedge of the SETUP cycle with req_valid low.
   // With decoy set, garbage is driven on the request fields while req_ready is low.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic err, input logic [31:0] rd,
                        input bit exp_rsp, input bit decoy);
      int     n;
      setup_t s;
      rsp_t   r;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      #1;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         if (decoy) begin
            bus.req_write = ~w;
            bus.req_addr  = a ^ 32'h0000_1FF0;
            bus.req_wdata = ~d;
         end
         @(negedge PCLK);
         #1;
         n++;
      end
      chk("accept_wait", 32'(bus.req_ready), 32'(1));
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      s = '{cyc + 1, !a[12], a[12], w, a, d};
      setup_q.push_back(s);
      if (exp_rsp) begin
         r = '{cyc + lat, err, rd};
         rsp_q.push_back(r);
      end
      @(negedge PCLK);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || setup_q.size() != 0) && n < 60) begin
         @(negedge PCLK);
         n++;
      end
      chk("drain_rsp", 32'(rsp_q.size()), 32'(0));
      @(negedge PCLK);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_psel1"}, 32'(bus.PSEL1), 32'(0));
      chk({tag, "_psel2"}, 32'(bus.PSEL2), 32'(0));
      chk({tag, "_penable"}, 32'(bus.PENABLE), 32'(0));
      chk({tag, "_pwrite"}, 32'(bus.PWRITE), 32'(0));
      chk({tag, "_paddr"}, bus.PADDR, 32'h0);
      chk({tag, "_pwdata"}, bus.PWDATA, 32'h0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(0));
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      PRESET = 1'b1;
      repeat (3) @(negedge PCLK);
      chk_reset_outputs("reset");
      PRESET = 1'b0;
      #1;
      chk("reset_release_ready", 32'(bus.req_ready), 32'(1));
      @(negedge PCLK);

      // zero-wait write to slave 1; rsp_rdata keeps its reset value
      wait_n = 0;
      issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 1'b1, 1'b0);
      wait_done();

      // read from slave 2 with three wait states
      wait_n = 3; slave_rdata = 32'h1234_5678;
      issue(1'b0, 32'h0000_1008, 32'h0, 6, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
      wait_done();

      // PREADY arrives in the last ACCESS cycle before the watchdog, slave 1
      wait_n = 3; slave_rdata = 32'hCAFE_F00D;
      issue(1'b0, 32'h0000_0FFC, 32'h0, 6, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
      wait_done();

      // back-to-back write slave 1 then read slave 2, second request held through SETUP
      wait_n = 0; slave_rdata = 32'hA5A5_5A5A;
      issue(1'b1, 32'h0000_0020, 32'h1111_1111, 3, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
      issue(1'b0, 32'h0000_1030, 32'h0, 3, 1'b0, 32'hA5A5_5A5A, 1'b1, 1'b1);
      wait_done();

      // watchdog abort: 4 ACCESS cycles, error response, read data unchanged
      wait_n = -1;
      issue(1'b0, 32'h0000_1100, 32'h0, 6, 1'b1, 32'hA5A5_5A5A, 1'b1, 1'b0);
      wait_done();

      // reset in the middle of ACCESS: no response, everything back to reset values
      wait_n = -1;
      issue(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b1;
      repeat (3) begin
         @(negedge PCLK);
         chk("midreset_psel1", 32'(bus.PSEL1), 32'(0));
         chk("midreset_psel2", 32'(bus.PSEL2), 32'(0));
         chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      end
      chk_reset_outputs("midreset");
      PRESET = 1'b0;
      #1;
      chk("midreset_release_ready", 32'(bus.req_ready), 32'(1));
      @(negedge PCLK);

      // recovery after reset
      wait_n = 0; slave_rdata = 32'h600D_F00D;
      issue(1'b1, 32'h0000_0010, 32'hFEED_FACE, 3, 1'b0, 32'h0, 1'b1, 1'b0);
      wait_done();
      issue(1'b0, 32'h0000_1FFC, 32'h0, 3, 1'b0, 32'h600D_F00D, 1'b1, 1'b0);
      wait_done();

      repeat (3) @(negedge PCLK);
      chk("final_setup_queue", 32'(setup_q.size()), 32'(0));
      chk("final_rsp_queue", 32'(rsp_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
